ysyx_220053_mem_arbiter: RTL and testbench
==========================================

Name: ysyx_220053_mem_arbiter

Overview:
- Shares the single memory bus port between two requesters: the instruction fetch side (IF) and the load/store side (M).
- Sits between the IFU/MU and the pmem DPI bridge.
- Grants one transaction at a time and latches the winning request.
- Drives the bus through a request/response handshake and routes the response back to the owner.
- Data side has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STARVE_MAX, 4, consecutive M grants allowed while IF waits before IF is forced through (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req_valid  in  1  IF fetch request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- m_req_valid  in  1  M load/store request
- m_req_ready  out  1  M request accepted this cycle
- m_addr  in  ADDR_W  load/store address
- m_wen  in  1  1 = store
- m_wdata  in  DATA_W  store data
- m_wmask  in  8  store byte mask
- m_rsp_valid  out  1  load data / store ack (1-cycle pulse)
- m_rdata  out  DATA_W  load data
- bus_req_valid  out  1  request to memory
- bus_req_ready  in  1  memory accepts request
- bus_addr  out  ADDR_W  latched address
- bus_wen  out  1  latched write enable
- bus_wdata  out  DATA_W  latched store data
- bus_wmask  out  8  latched mask (0 for fetch)
- bus_rsp_valid  in  1  memory response (reads and writes)
- bus_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- if_grant_cnt  out  32  IF grant counter (see Optional Feature)
- m_grant_cnt  out  32  M grant counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=IF, starve_cnt=0. All valid/ready outputs 0. bus_addr/bus_wdata/bus_wmask/bus_wen=0. Counters 0.
- FSM states: IDLE, REQ, RESP.
- IDLE grant (combinational ready, only in IDLE):
  - if m_req_valid && !(if_req_valid && starve_cnt==STARVE_MAX): grant M.
  - else if if_req_valid: grant IF.
  - Exactly one ready is high, and only to the winner.
- Grant (valid&ready) at clock edge:
  - Latch addr/wen/wdata/wmask; IF grant forces wen=0, wmask=0.
  - Set owner; go to REQ.
- starve_cnt:
  - +1 on an M grant while if_req_valid=1, saturating at STARVE_MAX.
  - Cleared on any IF grant.
  - Unchanged on an M grant with IF idle.
- REQ: bus_req_valid=1 with latched fields held stable. On bus_req_ready=1, go to RESP. No timeout.
- RESP: bus_req_valid=0. On bus_rsp_valid=1:
  - Owner's rsp_valid=1 in the same cycle; rdata passes through combinationally.
  - Go to IDLE.
  - Non-owner rsp_valid stays 0.
- rdata outputs equal bus_rdata at all times; they are meaningful only when rsp_valid=1.
- Timing: request accepted at edge N; bus_req_valid high from cycle N+1. With bus_req_ready=1 at N+1 and bus_rsp_valid=1 at N+2, rsp_valid pulses at N+2 and the next grant is possible at N+3.
- No new grant while busy; requesters hold valid until their ready is seen.
- bus_rsp_valid while in IDLE or REQ is ignored.
- Reset mid-transaction: abandon immediately and return to IDLE. A late bus_rsp_valid after reset is ignored.
- Simultaneous requests with starve_cnt<STARVE_MAX: M wins. At STARVE_MAX: IF wins.

Optional Feature:
- Macro: YSYX_220053_ARB_PERF_CNT_EN.
- Defined: if_grant_cnt / m_grant_cnt increment by 1 on each respective grant edge, saturating at 32'hFFFF_FFFF, cleared by rst.
- Undefined: both outputs are constant 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Single fetch: if_req_valid=1, addr=0x8000_0000; bus_req_ready=1 immediately; rsp 1 cycle later with rdata=0x0000_0013 -> if_req_ready pulse in cycle 0, bus_req_valid in cycle 1 with bus_addr=0x8000_0000 and wmask=0, if_rsp_valid with if_rdata=0x13 in cycle 2, busy back to 0 in cycle 3.
- Store: m_req_valid with wen=1, addr=0x8000_1000, wdata=0x1122334455667788, wmask=0x0F; bus_req_ready delayed 3 cycles -> bus fields stable through stall, m_rsp_valid on the ack, if_rsp_valid stays 0.
- Priority/starvation: both requesters held valid continuously, STARVE_MAX=4 -> grant order M,M,M,M,IF,M,M,M,M,IF.
- Reset mid-RESP: assert rst while waiting for bus_rsp_valid, then deliver bus_rsp_valid after rst deasserts -> all outputs 0 asynchronously, no rsp_valid pulse, busy=0.
- Stray response: bus_rsp_valid=1 in IDLE -> no rsp_valid, state unchanged.
- With YSYX_220053_ARB_PERF_CNT_EN: 3 IF and 5 M transactions -> if_grant_cnt=3, m_grant_cnt=5. Without the macro both read 0.

Source files
------------

// File: rtl/ysyx_220053_mem_arbiter.sv
`timescale 1ns/1ps
// ysyx_220053_mem_arbiter
// Shares one memory bus port between the instruction-fetch requester (IF)
// and the load/store requester (M). One transaction is in flight at a time.
// The winning request is latched, presented on the bus until the memory
// accepts it, and the memory response is routed back to the owner.
// M has priority. A starvation counter forces IF through after STARVE_MAX
// consecutive M grants taken while IF was waiting.
//
// Optional feature (macro YSYX_220053_ARB_PERF_CNT_EN): saturating grant
// counters on if_grant_cnt / m_grant_cnt. Without the macro, both outputs
// are tied to 0 and no counter flops are built.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   if_req_valid/ready, if_addr      fetch request handshake
//   if_rsp_valid, if_rdata           fetch response (1-cycle pulse)
//   m_req_valid/ready, m_addr,
//   m_wen, m_wdata, m_wmask          load/store request handshake
//   m_rsp_valid, m_rdata             load data / store ack (1-cycle pulse)
//   bus_req_valid/ready, bus_addr,
//   bus_wen, bus_wdata, bus_wmask    latched request toward memory
//   bus_rsp_valid, bus_rdata         memory response
//   busy                             a transaction is in progress
//   if_grant_cnt, m_grant_cnt        grant counters (optional feature)
module ysyx_220053_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              m_req_valid,
  output logic              m_req_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_wen,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [7:0]        m_wmask,
  output logic              m_rsp_valid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic [31:0]       if_grant_cnt,
  output logic [31:0]       m_grant_cnt
);

  localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner_m;   // 1: current transaction belongs to M
  logic [3:0]        r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;

  logic w_idle, w_starve_full, w_grant_m, w_grant_if;

  assign w_idle        = (r_state == S_IDLE);
  assign w_starve_full = (r_starve == LP_SMAX);
  // M wins unless IF is waiting and has already been passed over too often.
  assign w_grant_m     = w_idle && m_req_valid && !(if_req_valid && w_starve_full);
  assign w_grant_if    = w_idle && if_req_valid && !w_grant_m;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_m || w_grant_if) w_state_nxt = S_REQ;
      S_REQ:   if (bus_req_ready)           w_state_nxt = S_RESP;
      S_RESP:  if (bus_rsp_valid)           w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_req_ready   = w_grant_m;
    if_req_ready  = w_grant_if;
    bus_req_valid = (r_state == S_REQ);
    m_rsp_valid   = (r_state == S_RESP) && bus_rsp_valid &&  r_owner_m;
    if_rsp_valid  = (r_state == S_RESP) && bus_rsp_valid && !r_owner_m;
    busy          = !w_idle;
  end

  // Read data is a plain pass-through; only qualified by rsp_valid.
  assign if_rdata  = bus_rdata;
  assign m_rdata   = bus_rdata;
  assign bus_addr  = r_addr;
  assign bus_wen   = r_wen;
  assign bus_wdata = r_wdata;
  assign bus_wmask = r_wmask;

  // Request latch and owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_m <= 1'b0;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
    end else if (w_grant_m) begin
      r_owner_m <= 1'b1;
      r_addr    <= m_addr;
      r_wen     <= m_wen;
      r_wdata   <= m_wdata;
      r_wmask   <= m_wmask;
    end else if (w_grant_if) begin
      // Fetches are always reads with an empty mask.
      r_owner_m <= 1'b0;
      r_addr    <= if_addr;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
    end
  end

  // Starvation counter: counts M grants that bypassed a waiting IF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_starve <= '0;
    else if (w_grant_if)                                r_starve <= '0;
    else if (w_grant_m && if_req_valid && !w_starve_full) r_starve <= r_starve + 4'd1;
  end

`ifdef YSYX_220053_ARB_PERF_CNT_EN
  logic [31:0] r_if_cnt, r_m_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_cnt <= '0;
      r_m_cnt  <= '0;
    end else begin
      if (w_grant_if && (r_if_cnt != '1)) r_if_cnt <= r_if_cnt + 32'd1;
      if (w_grant_m  && (r_m_cnt  != '1)) r_m_cnt  <= r_m_cnt  + 32'd1;
    end
  end

  assign if_grant_cnt = r_if_cnt;
  assign m_grant_cnt  = r_m_cnt;
`else
  assign if_grant_cnt = '0;
  assign m_grant_cnt  = '0;
`endif

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for ysyx_220053_mem_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_ysyx_220053_mem_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        m_req_valid, m_req_ready, m_wen, m_rsp_valid;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wmask;
  logic        bus_req_valid, bus_req_ready, bus_wen, bus_rsp_valid, busy;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wmask;
  logic [31:0] if_grant_cnt, m_grant_cnt;

  int checks = 0;
  int errors = 0;

  ysyx_220053_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
    .busy(busy), .if_grant_cnt(if_grant_cnt), .m_grant_cnt(m_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef YSYX_220053_ARB_PERF_CNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  // One complete transaction with immediate bus accept and response.
  task automatic do_txn(input bit is_m);
    if (is_m) begin m_req_valid = 1'b1; m_addr = r64(); m_wen = 1'b0; end
    else begin if_req_valid = 1'b1; if_addr = r64(); end
    #2;
    tick();
    m_req_valid = 1'b0; if_req_valid = 1'b0; bus_req_ready = 1'b1;
    #2;
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1;
    #2;
    tick();
    bus_rsp_valid = 1'b0;
  endtask

  // Reference model state (transaction level)
  bit          md_busy, md_acc, md_own_m;
  logic [63:0] md_addr, md_wdata;
  logic        md_wen;
  logic [7:0]  md_wmask;
  int          md_starve, md_if_n, md_m_n;
  bit          pend_if, pend_m;

  bit exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bit eg_m, eg_if;
    rst = 1'b1;
    if_req_valid = 0; if_addr = 0; m_req_valid = 0; m_addr = 0;
    m_wen = 0; m_wdata = 0; m_wmask = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;

    // ---- reset state ----
    #2;
    chk("rst_bus_req_valid", bus_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_wmask", bus_wmask, 0);
    chk("rst_bus_wen", bus_wen, 0);
    chk("rst_if_rdy", if_req_ready, 0);
    chk("rst_m_rdy", m_req_ready, 0);
    chk("rst_if_cnt", if_grant_cnt, 0);
    chk("rst_m_cnt", m_grant_cnt, 0);
    tick(); tick();
    rst = 1'b0;

    // ---- single fetch ----
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    #2;
    chk("f_if_rdy", if_req_ready, 1);
    chk("f_m_rdy", m_req_ready, 0);
    tick();
    if_req_valid = 1'b0; bus_req_ready = 1'b1;
    #2;
    chk("f_bus_req_valid", bus_req_valid, 1);
    chk("f_bus_addr", bus_addr, 64'h8000_0000);
    chk("f_bus_wmask", bus_wmask, 0);
    chk("f_bus_wen", bus_wen, 0);
    chk("f_if_rsp_early", if_rsp_valid, 0);
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 64'h13;
    #2;
    chk("f_if_rsp", if_rsp_valid, 1);
    chk("f_if_rdata", if_rdata, 64'h13);
    chk("f_m_rsp", m_rsp_valid, 0);
    chk("f_bus_req_off", bus_req_valid, 0);
    tick();
    bus_rsp_valid = 1'b0;
    #2;
    chk("f_busy_done", busy, 0);
    tick();

    // ---- store with 3-cycle bus stall ----
    m_req_valid = 1'b1; m_wen = 1'b1; m_addr = 64'h8000_1000;
    m_wdata = 64'h1122334455667788; m_wmask = 8'h0F;
    #2;
    chk("s_m_rdy", m_req_ready, 1);
    chk("s_if_rdy", if_req_ready, 0);
    tick();
    m_req_valid = 1'b0; m_wen = 1'b0; m_addr = 0; m_wdata = 0; m_wmask = 0;
    for (int c = 0; c < 4; c++) begin
      bus_req_ready = (c == 3);
      #2;
      chk("s_bus_req_valid", bus_req_valid, 1);
      chk("s_bus_addr", bus_addr, 64'h8000_1000);
      chk("s_bus_wdata", bus_wdata, 64'h1122334455667788);
      chk("s_bus_wmask", bus_wmask, 8'h0F);
      chk("s_bus_wen", bus_wen, 1);
      tick();
    end
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 64'hDEAD_BEEF;
    #2;
    chk("s_m_rsp", m_rsp_valid, 1);
    chk("s_m_rdata", m_rdata, 64'hDEAD_BEEF);
    chk("s_if_rsp", if_rsp_valid, 0);
    tick();
    bus_rsp_valid = 1'b0;

    // ---- priority / starvation with both requesters always valid ----
    if_req_valid = 1'b1; m_req_valid = 1'b1;
    for (int g = 0; g < 10; g++) begin
      #2;
      chk("p_one_ready", 64'(if_req_ready) + 64'(m_req_ready), 1);
      chk("p_order_is_m", m_req_ready, exp_order[g]);
      tick();
      bus_req_ready = 1'b1;
      #2;
      tick();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1;
      #2;
      tick();
      bus_rsp_valid = 1'b0;
    end
    if_req_valid = 1'b0; m_req_valid = 1'b0;

    // ---- reset while waiting for the response ----
    if_req_valid = 1'b1; if_addr = 64'h8000_0040;
    #2;
    tick();
    if_req_valid = 1'b0; bus_req_ready = 1'b1;
    #2;
    tick();
    bus_req_ready = 1'b0;
    #2;
    chk("r_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("r_busy_async", busy, 0);
    chk("r_bus_req_valid", bus_req_valid, 0);
    chk("r_bus_addr", bus_addr, 0);
    chk("r_if_cnt", if_grant_cnt, 0);
    chk("r_m_cnt", m_grant_cnt, 0);
    tick(); tick();
    rst = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = r64();
    #2;
    chk("r_late_if_rsp", if_rsp_valid, 0);
    chk("r_late_m_rsp", m_rsp_valid, 0);
    chk("r_late_busy", busy, 0);
    tick();
    // ---- stray response in IDLE ----
    #2;
    chk("st_if_rsp", if_rsp_valid, 0);
    chk("st_m_rsp", m_rsp_valid, 0);
    tick();
    bus_rsp_valid = 1'b0;
    #2;
    chk("st_busy", busy, 0);
    chk("st_bus_req_valid", bus_req_valid, 0);
    tick();

    // ---- grant counters: 5 M, 3 IF ----
    for (int k = 0; k < 5; k++) do_txn(1'b1);
    for (int k = 0; k < 3; k++) do_txn(1'b0);
    #2;
    chk("cnt_if", if_grant_cnt, cnt_exp(3));
    chk("cnt_m", m_grant_cnt, cnt_exp(5));
    tick();

    // ---- randomized run against the reference model ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    md_busy = 0; md_acc = 0; md_own_m = 0; md_starve = 0; md_if_n = 0; md_m_n = 0;
    pend_if = 0; pend_m = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pend_if && ($urandom_range(0, 1) == 1)) begin
        pend_if = 1; if_addr = r64();
      end
      if (!pend_m && ($urandom_range(0, 1) == 1)) begin
        pend_m = 1; m_addr = r64(); m_wen = $urandom_range(0, 1) == 1;
        m_wdata = r64(); m_wmask = 8'($urandom);
      end
      if_req_valid = pend_if;
      m_req_valid  = pend_m;
      bus_req_ready = $urandom_range(0, 1) == 1;
      bus_rsp_valid = $urandom_range(0, 2) == 0;
      bus_rdata = r64();
      #2;
      eg_m  = !md_busy && pend_m && !(pend_if && md_starve == SMAX);
      eg_if = !md_busy && pend_if && !eg_m;
      chk("x_m_rdy", m_req_ready, eg_m);
      chk("x_if_rdy", if_req_ready, eg_if);
      chk("x_busy", busy, md_busy);
      chk("x_bus_req_valid", bus_req_valid, md_busy && !md_acc);
      if (md_busy && !md_acc) begin
        chk("x_bus_addr", bus_addr, md_addr);
        chk("x_bus_wen", bus_wen, md_wen);
        chk("x_bus_wmask", bus_wmask, md_wmask);
        if (md_own_m) chk("x_bus_wdata", bus_wdata, md_wdata);
      end
      chk("x_m_rsp", m_rsp_valid, md_busy && md_acc && bus_rsp_valid && md_own_m);
      chk("x_if_rsp", if_rsp_valid, md_busy && md_acc && bus_rsp_valid && !md_own_m);
      if (md_busy && md_acc && bus_rsp_valid)
        chk("x_rdata", md_own_m ? m_rdata : if_rdata, bus_rdata);
      chk("x_if_cnt", if_grant_cnt, cnt_exp(md_if_n));
      chk("x_m_cnt", m_grant_cnt, cnt_exp(md_m_n));
      // model update for the coming edge
      if (eg_m) begin
        if (pend_if && md_starve < SMAX) md_starve++;
        md_busy = 1; md_acc = 0; md_own_m = 1; md_m_n++;
        md_addr = m_addr; md_wen = m_wen; md_wdata = m_wdata; md_wmask = m_wmask;
        pend_m = 0;
      end else if (eg_if) begin
        md_starve = 0;
        md_busy = 1; md_acc = 0; md_own_m = 0; md_if_n++;
        md_addr = if_addr; md_wen = 0; md_wdata = 0; md_wmask = 0;
        pend_if = 0;
      end else if (md_busy && !md_acc && bus_req_ready) begin
        md_acc = 1;
      end else if (md_busy && md_acc && bus_rsp_valid) begin
        md_busy = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
